seq_stim_player: RTL and testbench
==================================

// Module: seq_stim_player
// PURPOSE
//  Upstream stimulus stage for the two-input sequence-detector FSM. Plays back a programmed
//  table of (i2,i1) symbols, each held for a programmable number of clk cycles, and drives
//  the detector's i2/i1 inputs. Replaces hand-timed stimulus with a deterministic,
//  cycle-exact, reusable pattern source.
// PARAMETERS
//  NUM_STEPS  12  table depth in entries; must be <= 2**ADDR_W
//  ADDR_W     4   table address width
//  HOLD_W     12  per-entry hold-count width, in cycles
// PORTS
//  clk       in   1           clock; all logic on posedge
//  reset     in   1           asynchronous, active-high reset
//  wr_en     in   1           table write strobe
//  wr_addr   in   ADDR_W      table write address
//  wr_data   in   HOLD_W+2    {hold[HOLD_W-1:0], i2, i1}
//  run_len   in   ADDR_W+1    number of entries to play; sampled on start
//  start     in   1           single-cycle start request
//  abort     in   1           synchronous stop request
//  i2        out  1           stimulus bit to detector
//  i1        out  1           stimulus bit to detector
//  step_idx  out  ADDR_W      index of the entry currently driven
//  busy      out  1           high while playing
//  done      out  1           one-cycle pulse after the last entry completes
// BEHAVIOUR
//  - Reset (async, any time, including mid-playback): state=IDLE; i2=i1=0, step_idx=0,
//    busy=0, done=0; hold counter=0; table entries cleared to 0.
//  - Writes: accepted at the clock edge when wr_en=1, busy=0 and wr_addr<NUM_STEPS.
//    Otherwise ignored: wr_en while busy, or wr_addr>=NUM_STEPS.
//  - FSM states: IDLE, PLAY, DONE.
//  - IDLE: i2=i1=0. If start=1, abort=0 and run_len!=0 at edge t:
//    - latch len = min(run_len, NUM_STEPS);
//    - go to PLAY; at edge t, drive entry 0 (i2/i1 valid from cycle t+1);
//    - busy=1, step_idx=0.
//    start with run_len=0 is ignored.
//  - PLAY: the current entry is held for H = max(hold,1) cycles; hold=0 counts as 1.
//    - At the edge ending the hold: if step_idx < len-1, advance step_idx and drive the
//      next entry on the same edge, with no gap cycle.
//    - Otherwise go to DONE and set i2=i1=0.
//  - DONE: lasts one cycle with done=1, busy=0. Then IDLE.
//  - Latency: start edge to first symbol = 1 cycle.
//    Total busy cycles = sum of H over played entries.
//  - abort=1 in PLAY: next edge -> IDLE, i2=i1=0, busy=0, no done pulse.
//  - abort=1 with start=1 in IDLE: abort wins; nothing starts.
//  - start while busy or in DONE is ignored; no queuing.
//  - The hold counter is HOLD_W bits, loaded with H-1 and decremented to 0; no wrap.
//  - The table is read combinationally from registers. Symbol outputs are registered, so
//    they are glitch-free toward the detector's level-sensitive next-state logic.
// CONFIGURATION
//  PATTERN_LOOP_EN defined:
//  - adds input port `loop` (1 bit).
//  - if loop=1 at the edge ending the last entry, playback wraps to entry 0 on that edge:
//    no gap, no done, busy stays 1.
//  - loop=0 behaves as one-shot.
//  - abort still stops playback.
//  PATTERN_LOOP_EN undefined:
//  - `loop` port does not exist; playback is always one-shot.
// TESTING
//  1. Reset during PLAY at step 3 -> outputs 0 immediately (async); busy=0; table reads 0.
//  2. Table {5,i2=0,i1=1},{3,1,1},{0,1,0}; run_len=3; start at edge t.
//     Required: (i2,i1)=01 for t+1..t+5, 11 for t+6..t+8, 10 at t+9; done=1 at t+10.
//  3. run_len=20 with NUM_STEPS=12 -> plays entries 0..11, then done; run_len=0 -> stays IDLE.
//  4. abort at 2nd cycle of entry 1 -> next cycle i2=i1=0, busy=0, done never asserted.
//  5. wr_en during playback to the entry being played -> table unchanged.
//     start during playback -> ignored.
//  6. With PATTERN_LOOP_EN, loop=1, 2 entries of hold 2 -> period-4 pattern repeats,
//     done stays 0. Without the macro -> one-shot, done after 4 cycles.

Source files
------------

// File: rtl/seq_stim_player.sv
// Stimulus player: replays a register table of (i2,i1) symbols, each held for a programmed
// number of cycles. Define PATTERN_LOOP_EN to add the `loop` input for continuous playback.
module seq_stim_player #(
  parameter int NUM_STEPS = 12,
  parameter int ADDR_W    = 4,
  parameter int HOLD_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [HOLD_W+1:0] wr_data,
  input  logic [ADDR_W:0]   run_len,
  input  logic              start,
  input  logic              abort,
`ifdef PATTERN_LOOP_EN
  input  logic              loop,
`endif
  output logic              i2,
  output logic              i1,
  output logic [ADDR_W-1:0] step_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  localparam logic [ADDR_W:0] NUM_STEPS_L = (ADDR_W+1)'(NUM_STEPS);

  state_t            state_q, state_d;
  logic [HOLD_W+1:0] tbl [NUM_STEPS];
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [1:0]        sym_q, sym_d;

  logic              loop_en;
  logic              wr_ok;
  logic              last;
  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W-1:0] fetch_idx;
  logic [HOLD_W+1:0] fetch_ent;
  logic [HOLD_W-1:0] fetch_hold;
  logic [HOLD_W-1:0] fetch_cnt;

`ifdef PATTERN_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  // Table is frozen for the whole playback so the running pattern cannot be corrupted.
  assign wr_ok = wr_en && (state_q != PLAY) && ({1'b0, wr_addr} < NUM_STEPS_L);

  // NOTE: the table is cleared by reset, which keeps it in flops rather than a RAM macro;
  // that is intended, since playback right after reset must be deterministic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STEPS; i++) tbl[i] <= '0;
    end else if (wr_ok) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  assign idx_inc = {1'b0, idx_q} + (ADDR_W+1)'(1);
  assign last    = (idx_inc >= len_q);

  // Entry to load next: entry 0 on start or wrap, otherwise the successor of the current one.
  always_comb begin
    fetch_idx = '0;
    if (state_q == PLAY && !last) fetch_idx = idx_inc[ADDR_W-1:0];
  end

  assign fetch_ent  = tbl[fetch_idx];
  assign fetch_hold = fetch_ent[HOLD_W+1:2];
  // A hold of 0 is treated as 1 cycle, so the counter is loaded with max(hold,1)-1.
  assign fetch_cnt  = (fetch_hold == '0) ? '0 : fetch_hold - HOLD_W'(1);

  // NOTE: the next-state block assigns defaults first so every path is covered and
  // no latch is inferred; it uses blocking assignments, the register block non-blocking.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sym_d   = sym_q;
    unique case (state_q)
      IDLE: begin
        sym_d = 2'b00;
        if (start && !abort && run_len != '0) begin
          state_d = PLAY;
          len_d   = (run_len > NUM_STEPS_L) ? NUM_STEPS_L : run_len;
          idx_d   = '0;
          sym_d   = fetch_ent[1:0];
          cnt_d   = fetch_cnt;
        end
      end
      PLAY: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          sym_d   = 2'b00;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - HOLD_W'(1);
        end else if (!last || loop_en) begin
          idx_d = fetch_idx;
          sym_d = fetch_ent[1:0];
          cnt_d = fetch_cnt;
        end else begin
          state_d = DONE;
          idx_d   = '0;
          sym_d   = 2'b00;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        sym_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      sym_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
    end
  end

  assign i2       = sym_q[1];
  assign i1       = sym_q[0];
  assign step_idx = idx_q;
  assign busy     = (state_q == PLAY);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_seq_stim_player.sv
// Self-checking bench for seq_stim_player: vector table, hand-written corner sequences and
// randomized playback against a per-cycle expected-symbol queue built from the table.
module tb_seq_stim_player;

  localparam int NS = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [13:0] wr_data;
  logic [4:0]  run_len;
  logic        start;
  logic        abort;
`ifdef PATTERN_LOOP_EN
  logic        loop;
`endif
  logic        i2, i1, busy, done;
  logic [3:0]  step_idx;

  seq_stim_player dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .run_len  (run_len),
    .start    (start),
    .abort    (abort),
`ifdef PATTERN_LOOP_EN
    .loop     (loop),
`endif
    .i2       (i2),
    .i1       (i1),
    .step_idx (step_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0] sym;
    int         idx;
  } exp_t;

  typedef struct {
    int run_len;
    int exp_busy;
  } vec_t;

  logic [13:0] mdl [NS];
  exp_t        q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got %0h, required %0h", name, act, req);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int hold, input logic [1:0] sym);
    wr_en   = 1'b1;
    wr_addr = addr[3:0];
    wr_data = {hold[11:0], sym};
    tick();
    wr_en = 1'b0;
    if (addr < NS) mdl[addr] = {hold[11:0], sym};
  endtask

  // Expected stream: each played entry contributes max(hold,1) cycles of its symbol.
  task automatic build_exp(input int rl);
    int n;
    int h;
    exp_t e;
    n = (rl > NS) ? NS : rl;
    q.delete();
    for (int k = 0; k < n; k++) begin
      h = int'(mdl[k][13:2]);
      if (h == 0) h = 1;
      e.sym = mdl[k][1:0];
      e.idx = k;
      for (int c = 0; c < h; c++) q.push_back(e);
    end
  endtask

  task automatic run_play(input int rl, input bit disturb, output int busy_cnt);
    build_exp(rl);
    busy_cnt = 0;
    run_len = rl[4:0];
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      check("play_sym", {i2, i1}, q[k].sym);
      check("play_idx", step_idx, q[k].idx);
      check("play_done", done, 1'b0);
      if (busy) busy_cnt++;
      // Start and a write to the active entry while playing must both be ignored.
      start   = disturb && (k == 0);
      wr_en   = disturb && (k == 0);
      wr_addr = q[k].idx[3:0];
      wr_data = ~mdl[q[k].idx];
      run_len = 5'd1;
      tick();
      start = 1'b0;
      wr_en = 1'b0;
    end
    if (q.size() > 0) begin
      check("done_pulse", done, 1'b1);
      check("done_busy", busy, 1'b0);
      check("done_sym", {i2, i1}, 2'b00);
      start   = disturb;
      run_len = 5'd2;
      tick();
      start = 1'b0;
    end
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);
    check("idle_sym", {i2, i1}, 2'b00);
    tick();
    check("idle_busy2", busy, 1'b0);
  endtask

  initial begin
    vec_t vecs [7];
    int   bc;
    int   guard;

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    run_len = '0; start = 1'b0; abort = 1'b0;
`ifdef PATTERN_LOOP_EN
    loop = 1'b0;
`endif
    for (int k = 0; k < NS; k++) mdl[k] = '0;
    #1;
    check("rst_sym", {i2, i1}, 2'b00);
    check("rst_idx", step_idx, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reference example: 01 x5, 11 x3, 10 x1, then done.
    wr(0, 5, 2'b01);
    wr(1, 3, 2'b11);
    wr(2, 0, 2'b10);
    run_play(3, 1'b0, bc);
    check("ex_busy_cycles", bc, 9);

    // Vector table on a fixed pattern: hold = k%3, so H = 1,1,2 repeating.
    for (int k = 0; k < NS; k++) wr(k, k % 3, k[1:0]);
    vecs[0] = '{0, 0};
    vecs[1] = '{1, 1};
    vecs[2] = '{3, 4};
    vecs[3] = '{5, 6};
    vecs[4] = '{12, 16};
    vecs[5] = '{13, 16};
    vecs[6] = '{20, 16};
    for (int v = 0; v < 7; v++) begin
      run_play(vecs[v].run_len, v[0], bc);
      check($sformatf("vec%0d_busy", v), bc, vecs[v].exp_busy);
    end

    // Writes beyond the table depth are dropped; the table above must be intact.
    wr(12, 7, 2'b11);
    wr(15, 7, 2'b11);
    run_play(12, 1'b0, bc);
    check("oob_busy", bc, 16);

    // Abort on the 2nd cycle of entry 1: no done pulse, outputs cleared next cycle.
    wr(0, 3, 2'b01);
    wr(1, 3, 2'b10);
    wr(2, 3, 2'b11);
    run_len = 5'd3;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("ab_sym", {i2, i1}, (k < 3) ? 2'b01 : 2'b10);
      if (k == 4) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("ab_sym_after", {i2, i1}, 2'b00);
      check("ab_busy", busy, 1'b0);
      check("ab_done", done, 1'b0);
      tick();
    end
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("ab_start_busy", busy, 1'b0);
    tick();
    check("ab_start_busy2", busy, 1'b0);

    // Two entries of hold 2: period-4 pattern when looping, else one-shot of 4 cycles.
    wr(0, 2, 2'b01);
    wr(1, 2, 2'b10);
`ifdef PATTERN_LOOP_EN
    loop    = 1'b1;
    run_len = 5'd2;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check("loop_sym", {i2, i1}, ((k % 4) < 2) ? 2'b01 : 2'b10);
      check("loop_busy", busy, 1'b1);
      check("loop_done", done, 1'b0);
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    loop  = 1'b0;
    check("loop_abort_busy", busy, 1'b0);
    check("loop_abort_sym", {i2, i1}, 2'b00);
    tick();
`else
    run_play(2, 1'b0, bc);
    check("oneshot_busy", bc, 4);
`endif

    // Asynchronous reset while entry 3 is playing.
    for (int k = 0; k < NS; k++) wr(k, 1, 2'b11);
    run_len = 5'd12;
    start   = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (step_idx != 4'd3 && guard < 50) begin
      tick();
      guard++;
    end
    check("rst_reach_step3", step_idx, 4'd3);
    #2 reset = 1'b1;
    #1;
    check("arst_sym", {i2, i1}, 2'b00);
    check("arst_busy", busy, 1'b0);
    check("arst_idx", step_idx, 4'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < NS; k++) mdl[k] = '0;
    tick();
    run_play(12, 1'b0, bc);
    check("arst_table_zero", bc, 12);

    // Randomized writes and playbacks against the expected-stream model.
    for (int it = 0; it < 15; it++) begin
      for (int w = 0; w < 3; w++)
        wr($urandom_range(0, 15), $urandom_range(0, 6), 2'($urandom_range(0, 3)));
      run_play($urandom_range(0, 20), 1'($urandom_range(0, 1)), bc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
